// File: rtl/unidad_control_segmentada.sv
// rtl/unidad_control_segmentada.sv - pipelined MIPS control unit with load-use stall, flush and illegal-opcode count
// Decodes in ID and carries WB/M/EX bundles through ID/EX, EX/MEM and MEM/WB.
module unidad_control_segmentada #(
  parameter int REGW   = 5,
  parameter int CNTW   = 8,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       IN,
  input  logic              EN,
  input  logic              FLUSH,
  output logic [ALUOPW+1:0] EX_EX,
  output logic [3:0]        M_MEM,
  output logic [1:0]        WB_WB,
  output logic              JUMP_ID,
  output logic              STALL,
  output logic              ILLEGAL,
  output logic [CNTW-1:0]   ILL_CNT
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [5:0]        opcode;
  logic [REGW-1:0]   rs_id;
  logic [REGW-1:0]   rt_id;
  logic [1:0]        wb_id;
  logic [3:0]        m_id;
  logic [ALUOPW+1:0] ex_id;
  logic              ill_id;
  logic              use_rs;
  logic              use_rt;
  logic              is_nop;

  logic [1:0]        idex_wb;
  logic [3:0]        idex_m;
  logic [ALUOPW+1:0] idex_ex;
  logic              idex_ill;
  logic [REGW-1:0]   rt_ex;
  logic [1:0]        exmem_wb;
  logic [3:0]        exmem_m;
  logic [1:0]        memwb_wb;
  logic [CNTW-1:0]   ill_cnt;
  logic              stall;

  assign opcode = IN[31:26];
  assign rs_id  = IN[21 +: REGW];
  assign rt_id  = IN[16 +: REGW];
  assign is_nop = (IN == 32'd0);

  // ex_id = {ALUSrc, ALUOp, RegDst}; m_id = {Jump, MemWrite, MemRead, Branch}; wb_id = {MemToReg, RegWrite}
  always_comb begin
    wb_id  = '0;
    m_id   = '0;
    ex_id  = '0;
    ill_id = 1'b0;
    use_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (!is_nop) begin
          wb_id  = 2'b01;
          ex_id  = {1'b0, ALUOPW'(3'b010), 1'b1};
          use_rt = 1'b1;
        end
      end
      OP_LW: begin
        wb_id = 2'b11;
        m_id  = 4'b0010;
        ex_id = {1'b1, ALUOPW'(3'b000), 1'b0};
      end
      OP_SW: begin
        m_id   = 4'b0100;
        ex_id  = {1'b1, ALUOPW'(3'b000), 1'b0};
        use_rt = 1'b1;
      end
      OP_BEQ: begin
        m_id   = 4'b0001;
        ex_id  = {1'b0, ALUOPW'(3'b001), 1'b0};
        use_rt = 1'b1;
      end
      OP_ADDI: begin
        wb_id = 2'b01;
        ex_id = {1'b1, ALUOPW'(3'b000), 1'b0};
      end
      OP_SLTI: begin
        wb_id = 2'b01;
        ex_id = {1'b1, ALUOPW'(3'b011), 1'b0};
      end
      OP_ANDI: begin
        wb_id = 2'b01;
        ex_id = {1'b1, ALUOPW'(3'b100), 1'b0};
      end
      OP_ORI: begin
        wb_id = 2'b01;
        ex_id = {1'b1, ALUOPW'(3'b101), 1'b0};
      end
      OP_J: begin
        m_id = 4'b1000;
      end
      default: begin
        ill_id = 1'b1;
      end
    endcase
    use_rs = !is_nop && (opcode != OP_J);
  end

  // A load in EX whose destination feeds the ID instruction must be separated by one bubble.
  assign stall = idex_m[1] && (rt_ex != '0) &&
                 ((use_rs && (rt_ex == rs_id)) || (use_rt && (rt_ex == rt_id)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idex_wb  <= '0;
      idex_m   <= '0;
      idex_ex  <= '0;
      idex_ill <= 1'b0;
      rt_ex    <= '0;
      exmem_wb <= '0;
      exmem_m  <= '0;
      memwb_wb <= '0;
      ill_cnt  <= '0;
    end else if (EN) begin
      memwb_wb <= exmem_wb;
      if (FLUSH) begin
        idex_wb  <= '0;
        idex_m   <= '0;
        idex_ex  <= '0;
        idex_ill <= 1'b0;
        rt_ex    <= '0;
        exmem_wb <= '0;
        exmem_m  <= '0;
      end else begin
        exmem_wb <= idex_wb;
        exmem_m  <= idex_m;
        if (stall) begin
          idex_wb  <= '0;
          idex_m   <= '0;
          idex_ex  <= '0;
          idex_ill <= 1'b0;
          rt_ex    <= '0;
        end else begin
          idex_wb  <= wb_id;
          idex_m   <= m_id;
          idex_ex  <= ex_id;
          idex_ill <= ill_id;
          rt_ex    <= rt_id;
          if (ill_id && (ill_cnt != {CNTW{1'b1}})) begin
            ill_cnt <= ill_cnt + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  assign EX_EX   = idex_ex;
  assign M_MEM   = exmem_m;
  assign WB_WB   = memwb_wb;
  assign ILLEGAL = idex_ill;
  assign ILL_CNT = ill_cnt;
  assign STALL   = stall;
  assign JUMP_ID = m_id[3] && !stall;

endmodule

// File: tb/tb_unidad_control_segmentada.sv
// tb/tb_unidad_control_segmentada.sv - scoreboard bench for unidad_control_segmentada
// The model tracks which instruction word occupies each stage and decodes it at the output.
module tb_unidad_control_segmentada;

  localparam int CNTW   = 2;
  localparam int CNTMAX = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] IN = 32'd0;
  logic [4:0]  EX_EX;
  logic [3:0]  M_MEM;
  logic [1:0]  WB_WB;
  logic        JUMP_ID;
  logic        STALL;
  logic        ILLEGAL;
  logic [CNTW-1:0] ILL_CNT;

  unidad_control_segmentada #(.REGW(5), .CNTW(CNTW), .ALUOPW(3)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .EN(EN), .FLUSH(FLUSH),
    .EX_EX(EX_EX), .M_MEM(M_MEM), .WB_WB(WB_WB), .JUMP_ID(JUMP_ID),
    .STALL(STALL), .ILLEGAL(ILLEGAL), .ILL_CNT(ILL_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rw, mtr, br, mr, mw, j, rd;
    logic [2:0] aluop;
    logic alusrc, ill;
  } ctl_t;

  typedef struct packed {
    logic [4:0] ex;
    logic [3:0] m;
    logic [1:0] wb;
    logic jump, stall, ill;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] ex_w = 32'd0;
  logic [31:0] mem_w = 32'd0;
  logic [31:0] wb_w = 32'd0;
  int cnt = 0;

  localparam logic [31:0] LW8   = {6'h23, 5'd9, 5'd8, 16'd0};
  localparam logic [31:0] LW0   = {6'h23, 5'd9, 5'd0, 16'd0};
  localparam logic [31:0] ADD8  = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADD0  = {6'h00, 5'd0, 5'd11, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] RADD  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADDI  = {6'h08, 5'd1, 5'd4, 16'd7};
  localparam logic [31:0] ORI   = {6'h0d, 5'd2, 5'd5, 16'd3};
  localparam logic [31:0] ILLW  = 32'hFC00_0000;

  function automatic ctl_t dec(input logic [31:0] w);
    ctl_t c;
    c = '0;
    case (w[31:26])
      6'h00: if (w != 32'd0) begin c.rw = 1; c.rd = 1; c.aluop = 3'd2; end
      6'h23: begin c.rw = 1; c.mtr = 1; c.mr = 1; c.alusrc = 1; end
      6'h2b: begin c.mw = 1; c.alusrc = 1; end
      6'h04: begin c.br = 1; c.aluop = 3'd1; end
      6'h08: begin c.rw = 1; c.alusrc = 1; end
      6'h0a: begin c.rw = 1; c.aluop = 3'd3; c.alusrc = 1; end
      6'h0c: begin c.rw = 1; c.aluop = 3'd4; c.alusrc = 1; end
      6'h0d: begin c.rw = 1; c.aluop = 3'd5; c.alusrc = 1; end
      6'h02: c.j = 1;
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic logic m_stall(input logic [31:0] w);
    ctl_t d = dec(ex_w);
    logic [4:0] rte = ex_w[20:16];
    logic urs = (w != 32'd0) && (w[31:26] != 6'h02);
    logic urt = (w[31:26] == 6'h00 && w != 32'd0) || (w[31:26] == 6'h2b) || (w[31:26] == 6'h04);
    return d.mr && (rte != 5'd0) && ((urs && rte == w[25:21]) || (urt && rte == w[20:16]));
  endfunction

  task automatic model_clear();
    ex_w = 0; mem_w = 0; wb_w = 0; cnt = 0;
  endtask

  // Applies the edge that just happened, using the inputs held during the previous cycle.
  task automatic model_edge();
    logic st;
    ctl_t d;
    if (RST) model_clear();
    else if (EN) begin
      st = m_stall(IN);
      d = dec(IN);
      wb_w = mem_w;
      if (FLUSH) begin
        mem_w = 0; ex_w = 0;
      end else begin
        mem_w = ex_w;
        if (st) ex_w = 0;
        else begin
          ex_w = IN;
          if (d.ill && cnt < CNTMAX) cnt = cnt + 1;
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    ctl_t x = dec(ex_w);
    ctl_t m = dec(mem_w);
    ctl_t b = dec(wb_w);
    ctl_t i = dec(IN);
    e.ex = {x.alusrc, x.aluop, x.rd};
    e.m = {m.j, m.mw, m.mr, m.br};
    e.wb = {b.mtr, b.rw};
    e.stall = m_stall(IN);
    e.jump = i.j && !e.stall;
    e.ill = x.ill;
    e.cnt = CNTW'(cnt);
    q.push_back(e);
  endtask

  task automatic step(input logic [31:0] w, input logic e, input logic f, input logic r);
    @(posedge CLK);
    #1;
    model_edge();
    RST = r;
    if (r) model_clear();
    IN = w; EN = e; FLUSH = f;
    push_exp();
  endtask

  // Re-presents an instruction while it is held in ID by a stall, as the frozen IF/ID would.
  task automatic issue(input logic [31:0] w, input logic e, input logic f);
    int guard = 0;
    step(w, e, f, 1'b0);
    while (m_stall(w) && guard < 3) begin
      step(w, e, f, 1'b0);
      guard++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a = 5'($urandom_range(0, 3));
    logic [4:0] b = 5'($urandom_range(0, 3));
    logic [4:0] c = 5'($urandom_range(0, 3));
    logic [15:0] imm = 16'($urandom);
    logic [5:0] ill_ops [5] = '{6'h3f, 6'h01, 6'h05, 6'h0f, 6'h30};
    case ($urandom_range(0, 10))
      0: return {6'h00, a, b, c, 5'd0, 6'h20};
      1: return {6'h23, a, b, imm};
      2: return {6'h2b, a, b, imm};
      3: return {6'h04, a, b, imm};
      4: return {6'h08, a, b, imm};
      5: return {6'h0a, a, b, imm};
      6: return {6'h0c, a, b, imm};
      7: return {6'h0d, a, b, imm};
      8: return {6'h02, 26'($urandom)};
      9: return 32'd0;
      default: return {ill_ops[$urandom_range(0, 4)], a, b, imm};
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_ex", 32'(EX_EX), 32'(e.ex));
        chk("m_mem", 32'(M_MEM), 32'(e.m));
        chk("wb_wb", 32'(WB_WB), 32'(e.wb));
        chk("jump_id", 32'(JUMP_ID), 32'(e.jump));
        chk("stall", 32'(STALL), 32'(e.stall));
        chk("illegal", 32'(ILLEGAL), 32'(e.ill));
        chk("ill_cnt", 32'(ILL_CNT), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    logic [31:0] w;
    logic e, f;
    step(32'd0, 1'b1, 1'b0, 1'b1);
    step(32'd0, 1'b1, 1'b0, 1'b1);
    // timing of a lone load
    issue(LW8, 1, 0);
    repeat (4) issue(32'd0, 1, 0);
    // load-use with and without a real destination
    issue(LW8, 1, 0); issue(ADD8, 1, 0);
    repeat (3) issue(32'd0, 1, 0);
    issue(LW0, 1, 0); issue(ADD0, 1, 0);
    repeat (3) issue(32'd0, 1, 0);
    // flush with an older instruction in MEM, then flush over a stall
    issue(RADD, 1, 0); issue(ADDI, 1, 0); issue(ORI, 1, 1);
    repeat (3) issue(32'd0, 1, 0);
    issue(LW8, 1, 0); issue(ADD8, 1, 1);
    repeat (3) issue(32'd0, 1, 0);
    // freeze
    issue(LW8, 1, 0); issue(ADDI, 1, 0);
    repeat (3) step(rand_instr(), 1'b0, 1'b0, 1'b0);
    issue(ORI, 1, 0);
    repeat (4) issue(32'd0, 1, 0);
    // illegal saturation
    repeat (5) issue(ILLW, 1, 0);
    issue(32'd0, 1, 0); issue(32'd0, 1, 0);
    // asynchronous reset with a load in flight
    issue(LW8, 1, 0); issue(32'd0, 1, 0);
    step(RADD, 1'b1, 1'b0, 1'b1);
    step(ADDI, 1'b1, 1'b0, 1'b0);
    repeat (4) issue(32'd0, 1, 0);
    // randomized traffic
    repeat (500) begin
      w = rand_instr();
      e = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) step(w, 1'b1, 1'b0, 1'b1);
      else issue(w, e, f);
    end
    repeat (3) @(posedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
